hilo_muldiv_unit: RTL and testbench
===================================

# hilo_muldiv_unit

Sequential HI/LO result unit sitting directly downstream of the combinational 32x32 signed Booth multiplier. It registers the operands that drive the multiplier and captures its 64-bit product into architectural HI/LO registers. It also performs signed 32-bit division iteratively (quotient to LO, remainder to HI) and handles direct HI/LO writes (MTHI/MTLO). A start/busy/done handshake connects it to the datapath controller.

## Interface

**Parameters**
- MUL_LATENCY, default 1: cycles between operand registration and product capture (range 1–4).

**Ports** (clock and reset first)
- clock  in  1  single system clock; all state updates on the rising edge.
- clear  in  1  reset, synchronous and active-high.
- start  in  1  request strobe; sampled only while busy=0.
- op  in  2  operation: 00 MUL, 01 DIV, 10 MTHI, 11 MTLO.
- opA  in  32  multiplicand / dividend / MTHI-MTLO source.
- opB  in  32  multiplier / divisor.
- mulHI, mulLO  in  32 each  product returned from the Booth multiplier instance.
- mulA, mulB  out  32 each  registered operands driving the multiplier's multiplicand and multiplier inputs.
- busy  out  1  operation in progress.
- done  out  1  one-cycle pulse; HI/LO hold the new values in this cycle.
- divByZero  out  1  set by a DIV with opB=0; cleared by the next accepted start.
- HI, LO  out  32 each  architectural HI/LO registers.

## Operation

- **Reset** (clear=1 at an edge): HI=LO=0, mulA=mulB=0, busy=0, done=0, divByZero=0, state IDLE.
- **States:** IDLE, MUL_WAIT, DIV_RUN, DIV_FIX.
- **IDLE + start:** the operation is accepted. divByZero is cleared (DIV by zero re-sets it at E1).
  - MUL: latch mulA=opA, mulB=opB; counter=MUL_LATENCY; go to MUL_WAIT.
  - DIV with opB≠0: latch |opA|, |opB|, and both signs; remainder=0; count=32; go to DIV_RUN.
  - DIV with opB=0: go to DIV_FIX with the zero flag set. No iterations run.
  - MTHI/MTLO: write HI (or LO) = opA at the accept edge; stay in IDLE.
- **MUL_WAIT:** decrement the counter. On the edge where it reaches 0: HI=mulHI, LO=mulLO, return to IDLE.
- **DIV_RUN:** restoring division, one quotient bit per cycle, MSB first, on unsigned magnitudes.
  - Shift {rem, quo} left by 1.
  - If rem ≥ divisor, subtract and set the quotient LSB.
  - The 33-bit subtract handles the magnitude 0x80000000.
  - After 32 iterations, go to DIV_FIX.
- **DIV_FIX:**
  - Normal case: LO = quotient, negated if the operand signs differ. HI = remainder, negated if the dividend was negative. Truncating division.
  - Zero-divisor case: HI/LO unchanged, divByZero=1.
  - Return to IDLE.
- **Overflow:** 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (two's-complement wrap). No flag is raised.
- **start while busy=1:** ignored; no queuing.
- **clear:** clear at the same edge as start, or at any point mid-operation, wins. The operation is aborted and all reset values are applied.
- HI/LO change only at MUL capture, DIV_FIX, MTHI/MTLO, or clear.

## Timing

- Accept edge = E0.
- **MUL:**
  - busy=1 from E0 until E(MUL_LATENCY).
  - HI/LO updated at E(MUL_LATENCY). At that edge busy falls and done rises for one cycle.
  - Default latency is 1.
- **DIV, opB≠0:**
  - busy=1 from E0 until E33. Iterations occur at E1..E32; sign fix at E33.
  - done is high for the one cycle after E33. Latency is 33 cycles.
- **DIV, opB=0:** busy=1 from E0 until E1. At E1: done=1, divByZero=1, HI/LO unchanged.
- **MTHI/MTLO:** busy stays 0; HI/LO updated at E0; done=1 for the cycle after E0.
- **Back-to-back:**
  - A new start may be asserted in the done cycle (busy=0) and is accepted at that edge.
  - done is never high for two consecutive cycles from the same operation.
- mulA/mulB must stay stable for the whole of MUL_WAIT. The multiplier path must settle within MUL_LATENCY cycles.

## Test plan

- **Reset:** clear for 2 cycles → HI=LO=mulA=mulB=0; busy=done=divByZero=0.
- **MUL (Booth instance connected, MUL_LATENCY=1):** opA=0xFFFFFFFD (−3), opB=7 → at E1 HI=0xFFFFFFFF, LO=0xFFFFFFEB, one-cycle done. Repeat with 0x7FFFFFFF×0x7FFFFFFF → HI=0x3FFFFFFF, LO=0x00000001.
- **DIV signs:**
  - 100/−7 → LO=0xFFFFFFF2, HI=0x00000002, done at E33.
  - −100/7 → LO=0xFFFFFFF2, HI=0xFFFFFFFE.
  - 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero:** preload HI=0x11, LO=0x22 via MTHI/MTLO, then DIV 5/0 → at E1 done=1, divByZero=1, HI=0x11, LO=0x22. Next MUL start clears divByZero.
- **Busy protection:** during DIV 1000/3, pulse start with op=MTLO at cycle 5 → ignored; final LO=333, HI=1.
- **Mid-operation clear:** clear at cycle 10 of DIV → next cycle all outputs at reset values; a new MUL 6×7 then yields LO=42, HI=0.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Sequential HI/LO result unit. Registers the operands feeding an external
//   combinational 32x32 signed multiplier and captures its 64-bit product into
//   HI/LO after MUL_LATENCY cycles. Performs signed 32-bit division with a
//   restoring, one-bit-per-cycle divider (quotient -> LO, remainder -> HI) and
//   handles direct MTHI/MTLO writes.
//
// Ports
//   clock        system clock, rising edge
//   clear        synchronous active-high reset
//   start        request strobe, honoured only while busy=0
//   op[1:0]      00 MUL, 01 DIV, 10 MTHI, 11 MTLO
//   opA, opB     operands (dividend/divisor, multiplicand/multiplier)
//   mulHI, mulLO product returned from the external multiplier
//   mulA, mulB   registered operands driving the external multiplier
//   busy         operation in progress
//   done         one-cycle pulse; HI/LO already hold the new values
//   divByZero    set by DIV with opB=0, cleared by the next accepted start
//   HI, LO       architectural HI/LO registers

module hilo_muldiv_unit #(
  parameter int MUL_LATENCY = 1
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] opA,
  input  logic [31:0] opB,
  input  logic [31:0] mulHI,
  input  logic [31:0] mulLO,
  output logic [31:0] mulA,
  output logic [31:0] mulB,
  output logic        busy,
  output logic        done,
  output logic        divByZero,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_RUN  = 2'd2,
    DIV_FIX  = 2'd3
  } state_t;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] mula_q, mula_d;
  logic [31:0] mulb_q, mulb_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] dvsr_q, dvsr_d;
  logic        negq_q, negq_d;    // quotient sign (operand signs differ)
  logic        negr_q, negr_d;    // remainder sign (dividend negative)
  logic        zero_q, zero_d;    // divisor was zero
  logic        done_q, done_d;
  logic        dbz_q, dbz_d;

  // Divider datapath: partial remainder shifted left with the next dividend
  // bit. 33 bits wide so that a divisor magnitude of 0x80000000 compares
  // correctly; bit 32 of the difference is the borrow.
  logic [32:0] shifted;
  logic [32:0] diff;

  assign shifted = {rem_q, quo_q[31]};
  assign diff    = shifted - {1'b0, dvsr_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    mula_d  = mula_q;
    mulb_d  = mulb_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    zero_d  = zero_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          case (op)
            OP_MUL: begin
              mula_d  = opA;
              mulb_d  = opB;
              cnt_d   = 6'(MUL_LATENCY);
              state_d = MUL_WAIT;
            end
            OP_DIV: begin
              negq_d  = opA[31] ^ opB[31];
              negr_d  = opA[31];
              quo_d   = opA[31] ? -opA : opA;
              dvsr_d  = opB[31] ? -opB : opB;
              rem_d   = '0;
              cnt_d   = 6'd32;
              zero_d  = (opB == '0);
              // A zero divisor skips the iterations entirely.
              state_d = (opB == '0) ? DIV_FIX : DIV_RUN;
            end
            OP_MTHI: begin
              hi_d   = opA;
              done_d = 1'b1;
            end
            OP_MTLO: begin
              lo_d   = opA;
              done_d = 1'b1;
            end
            default: ;
          endcase
        end
      end

      MUL_WAIT: begin
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          hi_d    = mulHI;
          lo_d    = mulLO;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      DIV_RUN: begin
        if (!diff[32]) begin
          rem_d = diff[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = shifted[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
        cnt_d = cnt_q - 6'd1;
        if (cnt_q == 6'd1) begin
          state_d = DIV_FIX;
        end
      end

      DIV_FIX: begin
        if (zero_q) begin
          dbz_d = 1'b1;
        end else begin
          // Truncating division: the -0x80000000 case wraps naturally.
          lo_d = negq_q ? -quo_q : quo_q;
          hi_d = negr_q ? -rem_q : rem_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      mula_q  <= '0;
      mulb_q  <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      mula_q  <= mula_d;
      mulb_q  <= mulb_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  assign mulA      = mula_q;
  assign mulB      = mulb_q;
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign divByZero = dbz_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit
//   Self-checking bench for hilo_muldiv_unit. A transaction-level model
//   (plain signed arithmetic plus a completion countdown) predicts HI, LO,
//   mulA, mulB, busy, done and divByZero; a compare process checks them on
//   every falling edge. Directed cases pin the model with literal values,
//   then randomized traffic (including stray starts and clears) runs.

module tb_hilo_muldiv_unit;

  localparam int LAT = 1;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic [1:0]  op;
  logic [31:0] opA, opB;
  logic [31:0] mulHI, mulLO;
  logic [31:0] mulA, mulB;
  logic        busy, done, divByZero;
  logic [31:0] HI, LO;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Behavioural stand-in for the combinational signed multiplier.
  logic signed [63:0] prod;
  assign prod = 64'($signed(mulA)) * 64'($signed(mulB));
  assign {mulHI, mulLO} = prod;

  hilo_muldiv_unit #(.MUL_LATENCY(LAT)) dut (
    .clock     (clock),
    .clear     (clear),
    .start     (start),
    .op        (op),
    .opA       (opA),
    .opB       (opB),
    .mulHI     (mulHI),
    .mulLO     (mulLO),
    .mulA      (mulA),
    .mulB      (mulB),
    .busy      (busy),
    .done      (done),
    .divByZero (divByZero),
    .HI        (HI),
    .LO        (LO)
  );

  // ---------------- reference model ----------------
  bit          m_valid = 0;
  logic [31:0] m_hi, m_lo, m_mula, m_mulb;
  bit          m_done, m_dbz;
  int          m_rem;          // edges left until the pending result lands
  logic [31:0] p_hi, p_lo;
  bit          p_wr, p_dbz;

  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    q  = 32'(sa / sb);
    r  = 32'(sa % sb);
  endfunction

  initial begin
    forever begin
      @(posedge clock);
      if (clear) begin
        m_valid = 1;
        m_hi = '0; m_lo = '0; m_mula = '0; m_mulb = '0;
        m_done = 0; m_dbz = 0; m_rem = 0;
      end else if (m_valid) begin
        m_done = 0;
        if (m_rem > 0) begin
          m_rem--;
          if (m_rem == 0) begin
            if (p_wr) begin
              m_hi = p_hi;
              m_lo = p_lo;
            end
            m_dbz  = p_dbz;
            m_done = 1;
          end
        end else if (start) begin
          m_dbz = 0;
          case (op)
            2'b00: begin
              longint pr;
              m_mula = opA;
              m_mulb = opB;
              pr = longint'($signed(opA)) * longint'($signed(opB));
              {p_hi, p_lo} = 64'(pr);
              p_wr = 1; p_dbz = 0; m_rem = LAT;
            end
            2'b01: begin
              if (opB == 32'd0) begin
                p_wr = 0; p_dbz = 1; m_rem = 1;
              end else begin
                ref_div(opA, opB, p_lo, p_hi);
                p_wr = 1; p_dbz = 0; m_rem = 33;
              end
            end
            2'b10: begin m_hi = opA; m_done = 1; end
            default: begin m_lo = opA; m_done = 1; end
          endcase
        end
      end
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Literal expectation checked against both the DUT and the model.
  task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] mdl,
                     input logic [31:0] exp);
    chk(nm, act, exp);
    chk({nm, "_model"}, mdl, exp);
    $display("check %s: dut=%h expected=%h", nm, act, exp);
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (m_valid) begin
        chk("HI", HI, m_hi);
        chk("LO", LO, m_lo);
        chk("mulA", mulA, m_mula);
        chk("mulB", mulB, m_mulb);
        chk("busy", 32'(busy), 32'(m_rem > 0));
        chk("done", 32'(done), 32'(m_done));
        chk("divByZero", 32'(divByZero), 32'(m_dbz));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; opA = a; opB = b;
    @(posedge clock); #1;
    start = 1'b0;
    $display("issue op=%0d a=%h b=%h", o, a, b);
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 100) begin
      @(posedge clock); #1;
      cyc++;
    end
    if (done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done after %0d cycles, required done", cyc);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      4: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int c;
    clear = 1'b1; start = 1'b0; op = 2'b00; opA = '0; opB = '0;
    repeat (2) @(posedge clock);
    #1;
    clear = 1'b0;
    lit("rst_HI", HI, m_hi, 32'h0);
    lit("rst_LO", LO, m_lo, 32'h0);
    lit("rst_mulA", mulA, m_mula, 32'h0);
    lit("rst_busy_done_dbz", {29'b0, busy, done, divByZero}, 32'h0, 32'h0);

    // MUL, then a back-to-back MUL issued in the done cycle
    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(c);
    chk("mul_latency", 32'(c), 32'(LAT));
    lit("mul1_HI", HI, m_hi, 32'hFFFF_FFFF);
    lit("mul1_LO", LO, m_lo, 32'hFFFF_FFEB);
    issue(2'b00, 32'h7FFF_FFFF, 32'h7FFF_FFFF);
    wait_done(c);
    lit("mul2_HI", HI, m_hi, 32'h3FFF_FFFF);
    lit("mul2_LO", LO, m_lo, 32'h0000_0001);

    // DIV sign cases and overflow
    issue(2'b01, 32'd100, -32'd7);
    wait_done(c);
    chk("div_latency", 32'(c), 32'd33);
    lit("div1_LO", LO, m_lo, 32'hFFFF_FFF2);
    lit("div1_HI", HI, m_hi, 32'h0000_0002);
    issue(2'b01, -32'd100, 32'd7);
    wait_done(c);
    lit("div2_LO", LO, m_lo, 32'hFFFF_FFF2);
    lit("div2_HI", HI, m_hi, 32'hFFFF_FFFE);
    issue(2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(c);
    lit("div3_LO", LO, m_lo, 32'h8000_0000);
    lit("div3_HI", HI, m_hi, 32'h0);

    // Divide by zero with preloaded HI/LO
    issue(2'b10, 32'h11, 32'h0);
    wait_done(c);
    chk("mthi_latency", 32'(c), 32'd0);
    issue(2'b11, 32'h22, 32'h0);
    wait_done(c);
    issue(2'b01, 32'd5, 32'd0);
    wait_done(c);
    chk("dbz_latency", 32'(c), 32'd1);
    lit("dbz_flag", 32'(divByZero), 32'(m_dbz), 32'd1);
    lit("dbz_HI", HI, m_hi, 32'h11);
    lit("dbz_LO", LO, m_lo, 32'h22);
    issue(2'b00, 32'd2, 32'd3);
    lit("dbz_cleared", 32'(divByZero), 32'(m_dbz), 32'd0);
    wait_done(c);

    // start while busy is ignored
    issue(2'b01, 32'd1000, 32'd3);
    repeat (4) begin @(posedge clock); #1; end
    start = 1'b1; op = 2'b11; opA = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(c);
    lit("busy_LO", LO, m_lo, 32'd333);
    lit("busy_HI", HI, m_hi, 32'd1);

    // clear mid-division
    issue(2'b01, 32'd12345, 32'd67);
    repeat (9) begin @(posedge clock); #1; end
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    lit("clr_HI", HI, m_hi, 32'h0);
    lit("clr_LO", LO, m_lo, 32'h0);
    lit("clr_busy_done_dbz", {29'b0, busy, done, divByZero}, 32'h0, 32'h0);
    issue(2'b00, 32'd6, 32'd7);
    wait_done(c);
    lit("clr_mul_LO", LO, m_lo, 32'd42);
    lit("clr_mul_HI", HI, m_hi, 32'd0);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      clear = ($urandom_range(0, 199) == 0);
      start = 1'($urandom_range(0, 1));
      op    = 2'($urandom_range(0, 3));
      opA   = pick();
      opB   = pick();
      @(posedge clock); #1;
    end
    clear = 1'b0;
    start = 1'b0;
    repeat (40) begin @(posedge clock); #1; end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
